// File: rtl/pong_pkg.sv
// Shared constants and state encoding for the pong ball engine.
// All geometry constants are 12 bits wide so comparisons never wrap.
package pong_pkg;

  typedef logic [11:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SERVE = 2'b01,
    ST_PLAY  = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam coord_t SCREEN_W  = 12'd640;
  localparam coord_t SCREEN_H  = 12'd480;
  localparam coord_t BALL_SIZE = 12'd10;
  localparam coord_t PADDLE_W  = 12'd10;
  localparam coord_t PADDLE_H  = 12'd50;
  localparam coord_t P1_X      = 12'd20;
  localparam coord_t P2_X      = 12'd610;
  localparam coord_t SPEED     = 12'd2;

  localparam logic [5:0] SERVE_LAST = 6'd59;  // SERVE_TICKS - 1
  localparam logic [3:0] WIN_SCORE  = 4'd10;

  // Rightmost / bottommost legal top-left corner of the ball.
  localparam coord_t X_LIMIT = SCREEN_W - BALL_SIZE;
  localparam coord_t Y_LIMIT = SCREEN_H - BALL_SIZE;

  localparam logic [10:0] CENTRE_X = 11'((SCREEN_W - BALL_SIZE) >> 1);
  localparam logic [9:0]  CENTRE_Y = 10'((SCREEN_H - BALL_SIZE) >> 1);

endpackage

// File: rtl/pong_ball_engine_if.sv
// Control/status bundle between the game-logic stage and its driver.
// The engine owns the outputs; tick/start/paddle positions come from outside.
interface pong_ball_engine_if;
  import pong_pkg::*;

  logic        tick;
  logic        start;
  logic [9:0]  paddle1_y;
  logic [9:0]  paddle2_y;
  logic [10:0] ball_x;
  logic [9:0]  ball_y;
  logic [3:0]  p1_score;
  logic [3:0]  p2_score;
  state_t      state;
  logic        game_over;

  modport master (
    output tick, start, paddle1_y, paddle2_y,
    input  ball_x, ball_y, p1_score, p2_score, state, game_over
  );

  modport slave (
    input  tick, start, paddle1_y, paddle2_y,
    output ball_x, ball_y, p1_score, p2_score, state, game_over
  );
endinterface

// File: rtl/pong_paddle_hit.sv
// Combinational paddle collision test for one paddle; the side is inferred
// from paddle_x, so the same module serves both the left and right paddle.
module pong_paddle_hit
  import pong_pkg::*;
(
  input  logic [10:0] ball_x,
  input  logic [9:0]  ball_y,
  input  logic [10:0] paddle_x,
  input  logic [9:0]  paddle_y,
  input  logic        dir_pos,
  output logic        hit,
  output logic [10:0] clamp_x
);

  logic   right_side;
  logic   overlap;
  logic   reach;
  coord_t bx;
  coord_t by;
  coord_t py;
  coord_t face;

  always_comb begin
    bx         = coord_t'(ball_x);
    by         = coord_t'(ball_y);
    py         = coord_t'(paddle_y);
    right_side = coord_t'(paddle_x) >= (SCREEN_W >> 1);
    // Right paddle: ball's left edge lands one ball-width before the paddle.
    // Left paddle: ball's left edge lands on the paddle's inner face.
    clamp_x    = right_side ? paddle_x - 11'(BALL_SIZE) : paddle_x + 11'(PADDLE_W);
    face       = coord_t'(clamp_x);
    overlap    = (by + BALL_SIZE > py) && (by < py + PADDLE_H);
    if (right_side)
      reach = dir_pos && (bx + SPEED >= face) && (bx < face);
    else
      reach = !dir_pos && (bx <= face + SPEED) && (bx > face);
    hit = reach && overlap;
  end

endmodule

// File: rtl/pong_ball_engine.sv
// Pong game logic: ball motion, wall/paddle collisions, scoring and the
// IDLE/SERVE/PLAY/DONE game FSM. Everything advances only on tick.
module pong_ball_engine
  import pong_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  pong_ball_engine_if.slave bus
);

  state_t      state_q, state_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        dx_q, dx_d;  // 1 = moving right
  logic        dy_q, dy_d;  // 1 = moving down
  logic [5:0]  cnt_q, cnt_d;
  logic [3:0]  s1_q, s1_d;
  logic [3:0]  s2_q, s2_d;
  logic        over_q, over_d;

  logic        hit_l, hit_r;
  logic [10:0] clamp_l, clamp_r;

  pong_paddle_hit u_hit_left (
    .ball_x   (x_q),
    .ball_y   (y_q),
    .paddle_x (11'(P1_X)),
    .paddle_y (bus.paddle1_y),
    .dir_pos  (dx_q),
    .hit      (hit_l),
    .clamp_x  (clamp_l)
  );

  pong_paddle_hit u_hit_right (
    .ball_x   (x_q),
    .ball_y   (y_q),
    .paddle_x (11'(P2_X)),
    .paddle_y (bus.paddle2_y),
    .dir_pos  (dx_q),
    .hit      (hit_r),
    .clamp_x  (clamp_r)
  );

  // NOTE: every next-state variable gets a default first so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    cnt_d   = cnt_q;
    s1_d    = s1_q;
    s2_d    = s2_q;

    if (bus.tick) begin
      unique case (state_q)
        ST_IDLE: begin
          x_d = CENTRE_X;
          y_d = CENTRE_Y;
          if (bus.start) begin
            s1_d    = '0;
            s2_d    = '0;
            dx_d    = 1'b1;
            dy_d    = 1'b1;
            cnt_d   = '0;
            state_d = ST_SERVE;
          end
        end

        ST_SERVE: begin
          x_d = CENTRE_X;
          y_d = CENTRE_Y;
          if (!bus.start)
            state_d = ST_IDLE;
          else if (cnt_q == SERVE_LAST)
            state_d = ST_PLAY;
          else
            cnt_d = cnt_q + 6'd1;
        end

        ST_PLAY: begin
          if (!bus.start) begin
            x_d     = CENTRE_X;
            y_d     = CENTRE_Y;
            state_d = ST_IDLE;
          end else begin
            // Vertical axis: bounce off top and bottom walls.
            if (!dy_q && coord_t'(y_q) < SPEED) begin
              y_d  = '0;
              dy_d = 1'b1;
            end else if (dy_q && coord_t'(y_q) + SPEED > Y_LIMIT) begin
              y_d  = 10'(Y_LIMIT);
              dy_d = 1'b0;
            end else begin
              y_d = dy_q ? y_q + 10'(SPEED) : y_q - 10'(SPEED);
            end

            // Horizontal axis: paddle returns first, then misses, else move.
            if (hit_r) begin
              x_d  = clamp_r;
              dx_d = 1'b0;
            end else if (hit_l) begin
              x_d  = clamp_l;
              dx_d = 1'b1;
            end else if (dx_q && coord_t'(x_q) + SPEED > X_LIMIT) begin
              s1_d    = (s1_q == WIN_SCORE) ? s1_q : s1_q + 4'd1;
              x_d     = CENTRE_X;
              y_d     = CENTRE_Y;
              dx_d    = 1'b0;
              cnt_d   = '0;
              state_d = (s1_d == WIN_SCORE) ? ST_DONE : ST_SERVE;
            end else if (!dx_q && coord_t'(x_q) < SPEED) begin
              s2_d    = (s2_q == WIN_SCORE) ? s2_q : s2_q + 4'd1;
              x_d     = CENTRE_X;
              y_d     = CENTRE_Y;
              dx_d    = 1'b1;
              cnt_d   = '0;
              state_d = (s2_d == WIN_SCORE) ? ST_DONE : ST_SERVE;
            end else begin
              x_d = dx_q ? x_q + 11'(SPEED) : x_q - 11'(SPEED);
            end
          end
        end

        ST_DONE: begin
          x_d = CENTRE_X;
          y_d = CENTRE_Y;
          if (!bus.start)
            state_d = ST_IDLE;
        end

        default: state_d = ST_IDLE;
      endcase
    end

    over_d = (state_d == ST_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q     <= CENTRE_X;
      y_q     <= CENTRE_Y;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      cnt_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      over_q  <= over_d;
    end
  end

  assign bus.ball_x    = x_q;
  assign bus.ball_y    = y_q;
  assign bus.p1_score  = s1_q;
  assign bus.p2_score  = s2_q;
  assign bus.state     = state_q;
  assign bus.game_over = over_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Self-checking bench for pong_ball_engine: directed game scenarios plus a
// randomized run, all compared against a tick-level behavioural game model.
module tb_pong_ball_engine;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pong_ball_engine_if bus ();

  pong_ball_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural game model ----------------
  localparam int W = 640, H = 480, B = 10, PW = 10, PH = 50;
  localparam int LX = 20, RX = 610, SP = 2, SERVE_N = 60, WIN = 10;
  localparam int CX = (W - B) / 2, CY = (H - B) / 2;

  int m_st, m_x, m_y, m_vx, m_vy, m_cnt, m_s1, m_s2;

  task automatic model_reset();
    m_st = 0; m_x = CX; m_y = CY; m_vx = SP; m_vy = SP;
    m_cnt = 0; m_s1 = 0; m_s2 = 0;
  endtask

  task automatic model_miss(input bit p1_scored);
    if (p1_scored) m_s1 = (m_s1 < WIN) ? m_s1 + 1 : m_s1;
    else           m_s2 = (m_s2 < WIN) ? m_s2 + 1 : m_s2;
    m_x  = CX; m_y = CY;
    m_vx = p1_scored ? -SP : SP;
    m_cnt = 0;
    m_st = ((p1_scored ? m_s1 : m_s2) == WIN) ? 3 : 1;
  endtask

  task automatic model_tick(input bit start, input int p1y, input int p2y);
    int y0, x0;
    bit ov1, ov2;
    case (m_st)
      0: if (start) begin
           m_s1 = 0; m_s2 = 0; m_vx = SP; m_vy = SP; m_cnt = 0; m_st = 1;
         end
      1: if (!start) m_st = 0;
         else if (m_cnt == SERVE_N - 1) m_st = 2;
         else m_cnt++;
      2: if (!start) begin
           m_st = 0; m_x = CX; m_y = CY;
         end else begin
           y0 = m_y; x0 = m_x;
           ov1 = (y0 + B > p1y) && (y0 < p1y + PH);
           ov2 = (y0 + B > p2y) && (y0 < p2y + PH);
           if (m_vy < 0 && y0 < SP) begin m_y = 0; m_vy = SP; end
           else if (m_vy > 0 && y0 + SP > H - B) begin m_y = H - B; m_vy = -SP; end
           else m_y = y0 + m_vy;
           if (m_vx > 0 && x0 + SP >= RX - B && x0 < RX - B && ov2) begin
             m_x = RX - B; m_vx = -SP;
           end else if (m_vx < 0 && x0 - SP <= LX + PW && x0 > LX + PW && ov1) begin
             m_x = LX + PW; m_vx = SP;
           end else if (m_vx > 0 && x0 + SP > W - B) model_miss(1'b1);
           else if (m_vx < 0 && x0 < SP) model_miss(1'b0);
           else m_x = x0 + m_vx;
         end
      default: if (!start) m_st = 0;
    endcase
  endtask

  // One clock: inputs were set before the edge; compare at the falling edge.
  task automatic cycle(input bit t);
    bus.tick = t;
    @(posedge clk);
    if (reset) model_reset();
    else if (t) model_tick(bus.start, int'(bus.paddle1_y), int'(bus.paddle2_y));
    @(negedge clk);
    check("ball_x",    32'(bus.ball_x),    m_x);
    check("ball_y",    32'(bus.ball_y),    m_y);
    check("p1_score",  32'(bus.p1_score),  m_s1);
    check("p2_score",  32'(bus.p2_score),  m_s2);
    check("state",     32'(bus.state),     m_st);
    check("game_over", 32'(bus.game_over), (m_st == 3) ? 1 : 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(1'b0);
    cycle(1'b1);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    bit found;
    reset = 1'b1;
    bus.tick = 1'b0; bus.start = 1'b0;
    bus.paddle1_y = 10'd0; bus.paddle2_y = 10'd400;
    model_reset();
    @(negedge clk);

    // 1: reset and idle behaviour
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1);
    check("idle_state", 32'(bus.state), 0);
    check("idle_x", 32'(bus.ball_x), 315);
    check("idle_y", 32'(bus.ball_y), 235);
    for (int i = 0; i < 100; i++) cycle(1'b0);
    check("hold_x", 32'(bus.ball_x), 315);

    // 2: serve countdown, then first play tick
    bus.start = 1'b1;
    cycle(1'b1);
    check("serve_enter", 32'(bus.state), 1);
    for (int i = 0; i < 59; i++) cycle(1'b1);
    check("serve_59", 32'(bus.state), 1);
    cycle(1'b1);
    check("play_enter", 32'(bus.state), 2);
    cycle(1'b1);
    check("first_x", 32'(bus.ball_x), 317);
    check("first_y", 32'(bus.ball_y), 237);

    // 3: bottom wall then right paddle bounce
    for (n = 2; n <= 143; n++) begin
      cycle(1'b1);
      if (n == 118) begin
        check("wall_y", 32'(bus.ball_y), 470);
        check("wall_x", 32'(bus.ball_x), 551);
      end
    end
    check("paddle_x", 32'(bus.ball_x), 600);
    check("paddle_y", 32'(bus.ball_y), 420);

    // 6: reset mid-play with tick held high
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      cycle(1'b1);
      if (m_x == 400) found = 1'b1;
    end
    check("reach_400", 32'(found), 1);
    reset = 1'b1; bus.tick = 1'b1;
    cycle(1'b1);
    reset = 1'b0;
    check("rst_state", 32'(bus.state), 0);
    check("rst_x", 32'(bus.ball_x), 315);
    check("rst_y", 32'(bus.ball_y), 235);

    // 4: right paddle out of the way -> p1 scores on play tick 158
    bus.paddle2_y = 10'd0;
    do_reset();
    cycle(1'b1);
    for (int i = 0; i < 60; i++) cycle(1'b1);
    for (int i = 1; i <= 158; i++) cycle(1'b1);
    check("miss_p1", 32'(bus.p1_score), 1);
    check("miss_state", 32'(bus.state), 1);
    check("miss_x", 32'(bus.ball_x), 315);
    for (int i = 0; i < 60; i++) cycle(1'b1);
    cycle(1'b1);
    check("serve_left_x", 32'(bus.ball_x), 313);

    // 5: left paddle tracks the ball, right paddle unreachable -> p1 wins
    bus.paddle2_y = 10'd1000;
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      bus.paddle1_y = 10'(m_y);
      cycle(1'b1);
      if (bus.state == 2'b11) found = 1'b1;
    end
    check("done_reached", 32'(found), 1);
    check("done_p1", 32'(bus.p1_score), 10);
    check("done_over", 32'(bus.game_over), 1);
    cycle(1'b1);
    check("done_frozen", 32'(bus.p1_score), 10);
    bus.start = 1'b0;
    cycle(1'b1);
    check("done_idle", 32'(bus.state), 0);
    check("idle_score_held", 32'(bus.p1_score), 10);
    bus.start = 1'b1;
    cycle(1'b1);
    check("restart_score", 32'(bus.p1_score), 0);
    check("restart_state", 32'(bus.state), 1);

    // Randomized play against the model
    for (int i = 0; i < 15000; i++) begin
      if (bus.start ? ($urandom_range(0, 399) == 0) : ($urandom_range(0, 9) == 0))
        bus.start = ~bus.start;
      if ($urandom_range(0, 199) == 0) bus.paddle1_y = 10'($urandom);
      if ($urandom_range(0, 199) == 0) bus.paddle2_y = 10'($urandom);
      if ($urandom_range(0, 4999) == 0) begin
        reset = 1'b1;
        cycle(1'($urandom));
        reset = 1'b0;
      end else begin
        cycle($urandom_range(0, 2) != 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
